// File: rtl/pipe_ctrl_n.sv
// pipe_ctrl_n: parametrised in-order pipeline sequencer.
// Resolves per-stage stall/flush requests by priority, owns the per-stage
// valid bits, drives stage load enables and keeps performance counters.
module pipe_ctrl_n #(
  parameter int unsigned NSTAGE = 5,
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned SIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic [NSTAGE-1:0] flush_req,
  input  logic              cnt_clr,
  output logic [NSTAGE-1:0] ena,
  output logic [NSTAGE-1:0] valid,
  output logic              in_ready,
  output logic              retire,
  output logic [SIDX_W-1:0] stall_idx,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  ret_cnt,
  output logic [CNT_W-1:0]  stl_cnt,
  output logic [CNT_W-1:0]  fls_cnt
);

  logic              flush_any;
  logic [SIDX_W-1:0] f_idx;
  logic [NSTAGE-1:0] younger_m;
  logic [NSTAGE-1:0] stall_m;
  logic              stall_any;
  logic [SIDX_W-1:0] s_idx;
  logic              flush_eff;
  logic [NSTAGE-1:0] ena_raw;
  logic [NSTAGE-1:0] bubble;
  logic [NSTAGE-1:0] kill;
  logic [NSTAGE-1:0] prev_valid;

  logic [NSTAGE-1:0] valid_q, valid_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [CNT_W-1:0]  stl_q, stl_d;
  logic [CNT_W-1:0]  fls_q, fls_d;

  // Flush priority encoder (oldest request wins) and mask of stages it kills.
  always_comb begin
    flush_any = 1'b0;
    f_idx     = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (flush_req[i]) begin
        flush_any = 1'b1;
        f_idx     = SIDX_W'(i);
      end
    end
    younger_m = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      younger_m[i] = flush_any && (SIDX_W'(i) < f_idx);
    end
  end

  // Stall priority encoder over requests not shadowed by the flush.
  always_comb begin
    stall_m   = stall_req & ~younger_m;
    stall_any = 1'b0;
    s_idx     = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (stall_m[i]) begin
        stall_any = 1'b1;
        s_idx     = SIDX_W'(i);
      end
    end
    // Any surviving stall sits at or above the flusher, so it suppresses it.
    flush_eff = flush_any && !stall_any;
  end

  // Load enables, bubble insertion point and kill vector.
  always_comb begin
    ena_raw = '1;
    bubble  = '0;
    kill    = '0;
    if (stall_any) begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (SIDX_W'(i) <= s_idx) ena_raw[i] = 1'b0;
      end
      for (int i = 1; i < NSTAGE; i++) begin
        bubble[i] = (SIDX_W'(i - 1) == s_idx);
      end
    end
    if (flush_eff) begin
      // Fetch is always refused on a flush, even when stage 0 itself flushes.
      kill       = younger_m;
      kill[0]    = 1'b1;
      ena_raw    = ena_raw & ~kill;
    end
  end

  // Next-state for valid bits and counters.
  always_comb begin
    prev_valid = {valid_q[NSTAGE-2:0], in_valid};
    valid_d    = valid_q;
    for (int i = 0; i < NSTAGE; i++) begin
      if (kill[i])         valid_d[i] = 1'b0;
      else if (ena_raw[i]) valid_d[i] = bubble[i] ? 1'b0 : prev_valid[i];
    end
    cyc_d = cnt_clr ? '0 : cyc_q + CNT_W'(1);
    ret_d = cnt_clr ? '0 : ret_q + CNT_W'(valid_q[NSTAGE-1] && ena_raw[NSTAGE-1]);
    stl_d = cnt_clr ? '0 : stl_q + CNT_W'(stall_any);
    fls_d = cnt_clr ? '0 : fls_q + CNT_W'(flush_eff);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      cyc_q   <= '0;
      ret_q   <= '0;
      stl_q   <= '0;
      fls_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cyc_q   <= cyc_d;
      ret_q   <= ret_d;
      stl_q   <= stl_d;
      fls_q   <= fls_d;
    end
  end

  // Outputs; combinational controls are forced quiet while reset is held.
  always_comb begin
    ena       = rst ? ena_raw : '0;
    in_ready  = ena[0];
    stall_idx = (rst && stall_any) ? s_idx : '0;
    valid     = valid_q;
    retire    = valid_q[NSTAGE-1];
    cyc_cnt   = cyc_q;
    ret_cnt   = ret_q;
    stl_cnt   = stl_q;
    fls_cnt   = fls_q;
  end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// tb_pipe_ctrl_n: directed self-checking bench for pipe_ctrl_n (NSTAGE=5).
module tb_pipe_ctrl_n;

  localparam int unsigned NS = 5;
  localparam int unsigned CW = 64;
  localparam int unsigned SW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [NS-1:0] stall_req;
  logic [NS-1:0] flush_req;
  logic          cnt_clr;
  logic [NS-1:0] ena;
  logic [NS-1:0] valid;
  logic          in_ready;
  logic          retire;
  logic [SW-1:0] stall_idx;
  logic [CW-1:0] cyc_cnt, ret_cnt, stl_cnt, fls_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl_n #(.NSTAGE(NS), .CNT_W(CW), .SIDX_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .stall_req (stall_req),
    .flush_req (flush_req),
    .cnt_clr   (cnt_clr),
    .ena       (ena),
    .valid     (valid),
    .in_ready  (in_ready),
    .retire    (retire),
    .stall_idx (stall_idx),
    .cyc_cnt   (cyc_cnt),
    .ret_cnt   (ret_cnt),
    .stl_cnt   (stl_cnt),
    .fls_cnt   (fls_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input int c, input int r, input int s, input int f);
    chk({tag, ".cyc"}, cyc_cnt, 64'(c));
    chk({tag, ".ret"}, ret_cnt, 64'(r));
    chk({tag, ".stl"}, stl_cnt, 64'(s));
    chk({tag, ".fls"}, fls_cnt, 64'(f));
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b1;
    stall_req = 5'b00010;
    flush_req = '0;
    cnt_clr   = 1'b0;

    // Reset state: controls quiet regardless of requests.
    #3;
    chk("rst.valid", valid, 0);
    chk("rst.ena", ena, 0);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.stall_idx", stall_idx, 0);
    chk("rst.retire", retire, 0);
    chk_cnt("rst", 0, 0, 0, 0);

    // Streaming fill.
    stall_req = '0;
    rst       = 1'b1;
    #1;
    chk("s1.ena", ena, 5'b11111);
    chk("s1.in_ready", in_ready, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("s1.fill", valid, 64'((1 << k) - 1));
      chk("s1.retire", retire, (k == 5) ? 1 : 0);
    end
    for (int k = 6; k <= 10; k++) tick();
    chk_cnt("s1.e10", 10, 5, 0, 0);
    tick();
    chk_cnt("s1.e11", 11, 6, 0, 0);

    // Load-use stall in stage 1.
    stall_req = 5'b00010;
    #1;
    chk("s2.ena", ena, 5'b11100);
    chk("s2.stall_idx", stall_idx, 1);
    chk("s2.in_ready", in_ready, 0);
    tick();
    chk("s2.valid", valid, 5'b11011);
    chk_cnt("s2", 12, 7, 1, 0);
    stall_req = '0;

    // Branch flush from stage 1 shadows the stage-0 stall.
    flush_req = 5'b00010;
    stall_req = 5'b00001;
    #1;
    chk("s3.ena", ena, 5'b11110);
    chk("s3.in_ready", in_ready, 0);
    chk("s3.stall_idx", stall_idx, 0);
    tick();
    chk("s3.valid", valid, 5'b10110);
    chk_cnt("s3", 13, 8, 1, 1);

    // Flush suppressed by an older stall.
    flush_req = 5'b00010;
    stall_req = 5'b00100;
    #1;
    chk("s4.ena", ena, 5'b11000);
    chk("s4.stall_idx", stall_idx, 2);
    tick();
    chk("s4.valid", valid, 5'b00110);
    chk_cnt("s4", 14, 9, 2, 1);
    flush_req = '0;
    stall_req = '0;

    // Refill to full.
    for (int k = 0; k < 5; k++) tick();
    chk("refill.valid", valid, 5'b11111);
    chk_cnt("refill", 19, 11, 2, 1);

    // WB stall freezes everything; retire held but counted once.
    stall_req = 5'b10000;
    #1;
    chk("s5.ena", ena, 5'b00000);
    chk("s5.stall_idx", stall_idx, 4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("s5.valid", valid, 5'b11111);
      chk("s5.retire", retire, 1);
      chk("s5.ret", ret_cnt, 11);
    end
    chk("s5.stl", stl_cnt, 5);
    stall_req = '0;
    tick();
    chk("s5.rel.ret", ret_cnt, 12);
    chk("s5.rel.valid", valid, 5'b11111);

    // Counter clear during a stall cycle wins over the increment.
    stall_req = 5'b00010;
    cnt_clr   = 1'b1;
    tick();
    chk_cnt("s6.clr", 0, 0, 0, 0);
    chk("s6.clr.valid", valid, 5'b11011);
    stall_req = '0;
    cnt_clr   = 1'b0;
    tick();
    chk_cnt("s6.post", 1, 1, 0, 0);
    chk("s6.post.valid", valid, 5'b10111);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b0;
    #1;
    chk("s6.arst.valid", valid, 0);
    chk("s6.arst.retire", retire, 0);
    chk("s6.arst.ena", ena, 0);
    chk_cnt("s6.arst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("s6.rel.valid", valid, 5'b00001);
    chk("s6.rel.cyc", cyc_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
